// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the 7-segment scan block.
// Segment order MSB..LSB: b,a,f,c,g,d,dp,e; active low.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int DP_BIT = 1;

  typedef enum logic {
    PH_DEAD,
    PH_ON
  } phase_e;

  function automatic logic [7:0] hex_seg(
    input logic [3:0] n
  );
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'h0A;
      4'h1: s = 8'h6F;
      4'h2: s = 8'h32;
      4'h3: s = 8'h23;
      4'h4: s = 8'h47;
      4'h5: s = 8'h83;
      4'h6: s = 8'h82;
      4'h7: s = 8'h2F;
      4'h8: s = 8'h02;
      4'h9: s = 8'h03;
      4'hA: s = 8'h06;
      4'hB: s = 8'hC2;
      4'hC: s = 8'h9A;
      4'hD: s = 8'h62;
      4'hE: s = 8'h92;
      default: s = 8'h96;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble + decimal point to active-low segment pattern.
// Segment order MSB..LSB: b,a,f,c,g,d,dp,e.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dot,
  output logic [7:0] seg
);

  always_comb begin
    seg = hex_seg(nibble);
    if (dot) seg[DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered frames,
// blanking, leading-zero suppression, dead time and PWM brightness.
module seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_BITS = 18,
  parameter int DEAD_CYC  = 64,
  parameter int BR_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dots_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [BR_BITS-1:0]    brightness,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic [7:0]            seg_out,
  output logic                  frame_tick
);

  localparam int IDX_W =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_DIGITS - 1);
  localparam logic [SCAN_BITS-1:0] DEAD_END =
    SCAN_BITS'(DEAD_CYC);

  logic [SCAN_BITS-1:0]  slot_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [4*N_DIGITS-1:0] pend_data;
  logic [4*N_DIGITS-1:0] shd_data;
  logic [N_DIGITS-1:0]   pend_dots;
  logic [N_DIGITS-1:0]   shd_dots;
  logic [N_DIGITS-1:0]   pend_blank;
  logic [N_DIGITS-1:0]   shd_blank;
  logic                  pend_lz;
  logic                  shd_lz;
  logic                  upd;
  logic                  tick_pre;

  logic                  slot_wrap;
  logic                  boundary;
  phase_e                phase;
  logic [BR_BITS-1:0]    pwm;
  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   dot_v;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [N_DIGITS-1:0]   eff_blank;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dot;
  logic                  lit;
  logic [7:0]            enc_seg;

  assign slot_wrap = &slot_cnt;
  assign boundary  = slot_wrap && (digit_idx == LAST_IDX);

  // Digit 0 sits in the top nibble / top dot bit.
  always_comb begin
    zero_run = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      nib[i]      = shd_data[4*(N_DIGITS-1-i) +: 4];
      dot_v[i]    = shd_dots[N_DIGITS-1-i];
      zero_run    = zero_run && (nib[i] == 4'h0);
      lz_blank[i] = shd_lz && (i < N_DIGITS - 1)
                    && zero_run;
    end
  end

  assign eff_blank = shd_blank | lz_blank;
  assign pwm       = slot_cnt[SCAN_BITS-1 -: BR_BITS];
  assign phase     = (slot_cnt < DEAD_END) ? PH_DEAD
                                           : PH_ON;
  assign cur_nib   = nib[digit_idx];
  assign cur_dot   = dot_v[digit_idx];
  assign lit       = (phase == PH_ON)
                     && (pwm <= brightness)
                     && !eff_blank[digit_idx];

  seg7_encode u_enc (
    .nibble (cur_nib),
    .dot    (cur_dot),
    .seg    (enc_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      pend_data  <= '0;
      pend_dots  <= '0;
      pend_blank <= '1;
      pend_lz    <= 1'b0;
      shd_data   <= '0;
      shd_dots   <= '0;
      shd_blank  <= '1;
      shd_lz     <= 1'b0;
      upd        <= 1'b0;
      tick_pre   <= 1'b0;
      frame_tick <= 1'b0;
      digit_sel  <= '0;
      seg_out    <= SEG_OFF;
    end else begin
      slot_cnt <= slot_cnt + SCAN_BITS'(1);
      if (slot_wrap) begin
        digit_idx <= (digit_idx == LAST_IDX) ? '0
                   : digit_idx + IDX_W'(1);
      end
      if (load) begin
        pend_data  <= data_in;
        pend_dots  <= dots_in;
        pend_blank <= blank_in;
        pend_lz    <= lz_en;
      end
      if (load) upd <= 1'b1;
      else if (boundary) upd <= 1'b0;
      // Shadow only moves at the frame edge, so no tearing.
      if (boundary && upd) begin
        shd_data  <= pend_data;
        shd_dots  <= pend_dots;
        shd_blank <= pend_blank;
        shd_lz    <= pend_lz;
      end
      tick_pre   <= boundary;
      frame_tick <= tick_pre;
      if (lit) begin
        digit_sel <= N_DIGITS'(1) << digit_idx;
        seg_out   <= enc_seg;
      end else begin
        digit_sel <= '0;
        seg_out   <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 16-cycle slot, 64-cycle frame.
// Frames are captured from the frame_tick cycle (output cycle 0, digit 0).
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SB = 4;
  localparam int DC = 2;
  localparam int BB = 2;

  logic          clk;
  logic          rst_n;
  logic [15:0]   data_in;
  logic [3:0]    dots_in;
  logic [3:0]    blank_in;
  logic          lz_en;
  logic          load;
  logic [1:0]    brightness;
  logic [3:0]    digit_sel;
  logic [7:0]    seg_out;
  logic          frame_tick;

  int checks;
  int errors;

  logic [3:0] cap_sel [64];
  logic [7:0] cap_seg [64];
  logic [3:0] e_sel [64];
  logic [7:0] e_seg [64];

  seg_scan_ctrl #(
    .N_DIGITS  (ND),
    .SCAN_BITS (SB),
    .DEAD_CYC  (DC),
    .BR_BITS   (BB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dots_in    (dots_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load       (load),
    .brightness (brightness),
    .digit_sel  (digit_sel),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic do_load(
    input logic [15:0] d,
    input logic [3:0]  dt,
    input logic [3:0]  bl,
    input logic        lz
  );
    @(negedge clk);
    data_in  = d;
    dots_in  = dt;
    blank_in = bl;
    lz_en    = lz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tick_timeout: got none, need one in 200");
    end
  endtask

  task automatic capture(input int skip);
    for (int s = 0; s <= skip; s++) wait_tick();
    cap_sel[0] = digit_sel;
    cap_seg[0] = seg_out;
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      cap_sel[c] = digit_sel;
      cap_seg[c] = seg_out;
    end
  endtask

  // segs = {digit0..digit3}; FF marks a digit expected dark.
  function automatic void build_exp(
    input logic [31:0] segs,
    input int          lim
  );
    logic [7:0] s;
    int d;
    int k;
    for (int c = 0; c < 64; c++) begin
      d = c / 16;
      k = c % 16;
      s = segs[31-8*d -: 8];
      if (s != 8'hFF && k >= 2 && k <= lim) begin
        e_sel[c] = 4'(1 << d);
        e_seg[c] = s;
      end else begin
        e_sel[c] = 4'b0000;
        e_seg[c] = 8'hFF;
      end
    end
  endfunction

  task automatic test_reset();
    int  n;
    bit  dark;
    checks++;
    if (digit_sel !== 4'b0000) begin
      errors++;
      $display("FAIL rst_sel: got %b need 0000", digit_sel);
    end
    checks++;
    if (seg_out !== 8'hFF) begin
      errors++;
      $display("FAIL rst_seg: got %h need ff", seg_out);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick: got %b need 0", frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_load(16'h0123, 4'b0000, 4'b0000, 1'b0);
    wait_tick();
    wait_tick();
    repeat (5) @(negedge clk);
    checks++;
    if (digit_sel !== 4'b0001 || seg_out !== 8'h0A) begin
      errors++;
      $display("FAIL pre_rst_lit: got %b/%h need 0001/0a",
               digit_sel, seg_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (digit_sel !== 4'b0000 || seg_out !== 8'hFF) begin
      errors++;
      $display("FAIL async_rst: got %b/%h need 0000/ff",
               digit_sel, seg_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    for (int f = 0; f < 3; f++) begin
      n = 0;
      dark = 1'b1;
      do begin
        @(negedge clk);
        n++;
        if (digit_sel !== 4'b0000 || seg_out !== 8'hFF)
          dark = 1'b0;
      end while (frame_tick !== 1'b1 && n < 200);
      checks++;
      if (n != 64) begin
        errors++;
        $display("FAIL tick_gap: got %0d need 64", n);
      end
      checks++;
      if (!dark) begin
        errors++;
        $display("FAIL dark_after_rst: got lit need dark");
      end
    end
  endtask

  task automatic test_basic();
    brightness = 2'd3;
    do_load(16'h0123, 4'b0000, 4'b0000, 1'b0);
    capture(1);
    build_exp({8'h0A, 8'h6F, 8'h32, 8'h23}, 15);
    for (int c = 0; c < 64; c++) begin
      checks += 2;
      if (cap_sel[c] !== e_sel[c]) begin
        errors++;
        $display("FAIL basic_sel c%0d: got %b need %b",
                 c, cap_sel[c], e_sel[c]);
      end
      if (cap_seg[c] !== e_seg[c]) begin
        errors++;
        $display("FAIL basic_seg c%0d: got %h need %h",
                 c, cap_seg[c], e_seg[c]);
      end
    end
  endtask

  task automatic test_dots_blank();
    do_load(16'h1000, 4'b1000, 4'b0100, 1'b0);
    capture(1);
    build_exp({8'h6D, 8'h0A, 8'hFF, 8'h0A}, 15);
    for (int c = 0; c < 64; c++) begin
      checks += 2;
      if (cap_sel[c] !== e_sel[c]) begin
        errors++;
        $display("FAIL dotblk_sel c%0d: got %b need %b",
                 c, cap_sel[c], e_sel[c]);
      end
      if (cap_seg[c] !== e_seg[c]) begin
        errors++;
        $display("FAIL dotblk_seg c%0d: got %h need %h",
                 c, cap_seg[c], e_seg[c]);
      end
    end
  endtask

  task automatic test_lz();
    do_load(16'h0012, 4'b0000, 4'b0000, 1'b1);
    capture(1);
    build_exp({8'hFF, 8'hFF, 8'h6F, 8'h32}, 15);
    for (int c = 0; c < 64; c++) begin
      checks += 2;
      if (cap_sel[c] !== e_sel[c]) begin
        errors++;
        $display("FAIL lz12_sel c%0d: got %b need %b",
                 c, cap_sel[c], e_sel[c]);
      end
      if (cap_seg[c] !== e_seg[c]) begin
        errors++;
        $display("FAIL lz12_seg c%0d: got %h need %h",
                 c, cap_seg[c], e_seg[c]);
      end
    end
    do_load(16'h0000, 4'b1111, 4'b0000, 1'b1);
    capture(1);
    build_exp({8'hFF, 8'hFF, 8'hFF, 8'h08}, 15);
    for (int c = 0; c < 64; c++) begin
      checks += 2;
      if (cap_sel[c] !== e_sel[c]) begin
        errors++;
        $display("FAIL lz00_sel c%0d: got %b need %b",
                 c, cap_sel[c], e_sel[c]);
      end
      if (cap_seg[c] !== e_seg[c]) begin
        errors++;
        $display("FAIL lz00_seg c%0d: got %h need %h",
                 c, cap_seg[c], e_seg[c]);
      end
    end
  endtask

  task automatic test_brightness();
    int lim [3];
    logic [1:0] br [3];
    br[0] = 2'd1; lim[0] = 7;
    br[1] = 2'd0; lim[1] = 3;
    br[2] = 2'd3; lim[2] = 15;
    do_load(16'h0123, 4'b0000, 4'b0000, 1'b0);
    for (int t = 0; t < 3; t++) begin
      brightness = br[t];
      capture(t == 0 ? 1 : 0);
      build_exp({8'h0A, 8'h6F, 8'h32, 8'h23}, lim[t]);
      for (int c = 0; c < 64; c++) begin
        checks += 2;
        if (cap_sel[c] !== e_sel[c]) begin
          errors++;
          $display("FAIL br%0d_sel c%0d: got %b need %b",
                   br[t], c, cap_sel[c], e_sel[c]);
        end
        if (cap_seg[c] !== e_seg[c]) begin
          errors++;
          $display("FAIL br%0d_seg c%0d: got %h need %h",
                   br[t], c, cap_seg[c], e_seg[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    brightness = 2'd3;
    do_load(16'h4567, 4'b0000, 4'b0000, 1'b0);
    wait_tick();
    wait_tick();
    checks++;
    if (digit_sel !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_dead: got %b need 0000", digit_sel);
    end
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      if (c == 20) begin
        data_in = 16'hAAAA;
        load = 1'b1;
      end else if (c == 36) begin
        data_in = 16'hBBBB;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (c == 5) begin
        checks++;
        if (digit_sel !== 4'b0001 || seg_out !== 8'h47) begin
          errors++;
          $display("FAIL b2b_old0: got %b/%h need 0001/47",
                   digit_sel, seg_out);
        end
      end
      if (c == 40) begin
        checks++;
        if (digit_sel !== 4'b0100 || seg_out !== 8'h82) begin
          errors++;
          $display("FAIL b2b_old2: got %b/%h need 0100/82",
                   digit_sel, seg_out);
        end
      end
      if (c == 56) begin
        checks++;
        if (digit_sel !== 4'b1000 || seg_out !== 8'h2F) begin
          errors++;
          $display("FAIL b2b_old3: got %b/%h need 1000/2f",
                   digit_sel, seg_out);
        end
      end
    end
    capture(0);
    build_exp({8'hC2, 8'hC2, 8'hC2, 8'hC2}, 15);
    for (int c = 0; c < 64; c++) begin
      checks += 2;
      if (cap_sel[c] !== e_sel[c]) begin
        errors++;
        $display("FAIL b2b_sel c%0d: got %b need %b",
                 c, cap_sel[c], e_sel[c]);
      end
      if (cap_seg[c] !== e_seg[c]) begin
        errors++;
        $display("FAIL b2b_seg c%0d: got %h need %h",
                 c, cap_seg[c], e_seg[c]);
      end
    end
    // Load lands on the boundary clock edge itself.
    wait_tick();
    repeat (62) @(negedge clk);
    data_in = 16'hDDDD;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    capture(0);
    checks++;
    if (cap_sel[2] !== 4'b0001 || cap_seg[2] !== 8'hC2) begin
      errors++;
      $display("FAIL bnd_old: got %b/%h need 0001/c2",
               cap_sel[2], cap_seg[2]);
    end
    capture(0);
    checks++;
    if (cap_sel[2] !== 4'b0001 || cap_seg[2] !== 8'h62) begin
      errors++;
      $display("FAIL bnd_new: got %b/%h need 0001/62",
               cap_sel[2], cap_seg[2]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    data_in    = '0;
    dots_in    = '0;
    blank_in   = '0;
    lz_en      = 1'b0;
    load       = 1'b0;
    brightness = 2'd3;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_dots_blank();
    test_lz();
    test_brightness();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
